// File: rtl/mic_fir_arbiter.sv
// Shares one FIR between three mic channels: round-robin issue plus an in-order tag FIFO that routes results back.
// Define MIC_FIR_ARBITER_STATUS_EN to build the sticky overrun/orphan flags; otherwise those outputs are tied 0.
module mic_fir_arbiter #(
    parameter int TAG_DEPTH = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [2:0]  sample_valid_in,
    input  logic [15:0] sample_in_0,
    input  logic [15:0] sample_in_1,
    input  logic [15:0] sample_in_2,
    output logic [15:0] fir_tdata_out,
    output logic        fir_tvalid_out,
    input  logic        fir_tready_in,
    input  logic        fir_res_valid_in,
    input  logic [15:0] fir_res_data_in,
    output logic [15:0] filtered_out_0,
    output logic [15:0] filtered_out_1,
    output logic [15:0] filtered_out_2,
    output logic [2:0]  filtered_valid_out,
    output logic [2:0]  overrun_out,
    output logic        orphan_out
);
    localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(TAG_DEPTH);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    logic [15:0]      sample_arr [3];
    logic [15:0]      hold [3];
    logic [2:0]       pending;
    logic [15:0]      filt [3];
    logic [2:0]       filt_valid;
    logic [2:0]       overrun;

    logic [0:0]       state_reg, state_next;
    logic [1:0]       grant_ch_reg;
    logic [1:0]       last_grant_reg;
    logic [15:0]      tdata_reg;

    logic [1:0]       tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg, count_next;

    logic [1:0]       start_ch;
    logic [1:0]       pick;
    logic             pick_valid;
    logic             grant;
    logic             push;
    logic             pop;
    logic [1:0]       head_tag;

    assign sample_arr[0] = sample_in_0;
    assign sample_arr[1] = sample_in_1;
    assign sample_arr[2] = sample_in_2;

    function automatic logic [1:0] wrap3(input logic [2:0] v);
        return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
    endfunction

    // Nearest pending channel at or after start_ch wins; loop runs far-to-near so the nearest overwrites.
    assign start_ch = wrap3({1'b0, last_grant_reg} + 3'd1);

    always_comb begin
        pick       = start_ch;
        pick_valid = 1'b0;
        for (int k = 2; k >= 0; k--) begin
            if (pending[wrap3({1'b0, start_ch} + 3'(k))]) begin
                pick       = wrap3({1'b0, start_ch} + 3'(k));
                pick_valid = 1'b1;
            end
        end
    end

    // Full check uses the pre-edge count, so a same-edge pop does not unblock issue.
    assign grant    = (state_reg == ST_IDLE) && pick_valid && (count_reg != FULL_COUNT);
    assign push     = (state_reg == ST_ISSUE) && fir_tready_in;
    assign pop      = fir_res_valid_in && (count_reg != '0);
    assign head_tag = tag_mem[rd_ptr_reg];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (grant) state_next = ST_ISSUE;
            default:  if (fir_tready_in) state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg      <= ST_IDLE;
            tdata_reg      <= '0;
            grant_ch_reg   <= '0;
            last_grant_reg <= 2'd2;
        end else begin
            state_reg <= state_next;
            if (grant) begin
                tdata_reg      <= hold[pick];
                grant_ch_reg   <= pick;
                last_grant_reg <= pick;
            end
        end
    end

    assign fir_tvalid_out = (state_reg == ST_ISSUE);
    assign fir_tdata_out  = tdata_reg;

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (push && !rst_in) begin
            tag_mem[wr_ptr_reg] <= grant_ch_reg;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_next;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_ch
            logic        pending_reg;
            logic [15:0] hold_reg;
            logic [15:0] filt_reg;
            logic        filt_valid_reg;
            logic        granted;
            logic        hit;

            assign granted = grant && (pick == 2'(gi));
            assign hit     = pop && (head_tag == 2'(gi));

            // A strobe on the granting edge refills the hold register, so pending stays set.
            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    pending_reg <= 1'b0;
                    hold_reg    <= '0;
                end else if (sample_valid_in[gi]) begin
                    pending_reg <= 1'b1;
                    hold_reg    <= sample_arr[gi];
                end else if (granted) begin
                    pending_reg <= 1'b0;
                end
            end

            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    filt_reg       <= '0;
                    filt_valid_reg <= 1'b0;
                end else begin
                    filt_valid_reg <= hit;
                    if (hit) filt_reg <= fir_res_data_in;
                end
            end

`ifdef MIC_FIR_ARBITER_STATUS_EN
            logic overrun_reg;
            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    overrun_reg <= 1'b0;
                end else if (sample_valid_in[gi] && pending_reg && !granted) begin
                    overrun_reg <= 1'b1;
                end
            end
            assign overrun[gi] = overrun_reg;
`else
            assign overrun[gi] = 1'b0;
`endif

            assign pending[gi]    = pending_reg;
            assign hold[gi]       = hold_reg;
            assign filt[gi]       = filt_reg;
            assign filt_valid[gi] = filt_valid_reg;
        end
    endgenerate

`ifdef MIC_FIR_ARBITER_STATUS_EN
    logic orphan_reg;
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            orphan_reg <= 1'b0;
        end else if (fir_res_valid_in && (count_reg == '0)) begin
            orphan_reg <= 1'b1;
        end
    end
    assign orphan_out = orphan_reg;
`else
    assign orphan_out = 1'b0;
`endif

    assign filtered_out_0     = filt[0];
    assign filtered_out_1     = filt[1];
    assign filtered_out_2     = filt[2];
    assign filtered_valid_out = filt_valid;
    assign overrun_out        = overrun;

endmodule

// File: tb/tb_mic_fir_arbiter.sv
// Directed bench for mic_fir_arbiter: a queue-based reference model checked every cycle, plus literal expectations.
module tb_mic_fir_arbiter;
    localparam int DEPTH = 4;
`ifdef MIC_FIR_ARBITER_STATUS_EN
    localparam bit STATUS = 1'b1;
`else
    localparam bit STATUS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  sv = '0;
    logic [15:0] s0 = '0, s1 = '0, s2 = '0;
    logic [15:0] tdata;
    logic        tvalid;
    logic        tready = 1'b0;
    logic        res_valid = 1'b0;
    logic [15:0] res_data = '0;
    logic [15:0] f0, f1, f2;
    logic [2:0]  fv;
    logic [2:0]  ovr;
    logic        orph;

    always #5 clk = ~clk;

    mic_fir_arbiter #(.TAG_DEPTH(DEPTH)) dut (
        .clk_in(clk), .rst_in(rst), .sample_valid_in(sv),
        .sample_in_0(s0), .sample_in_1(s1), .sample_in_2(s2),
        .fir_tdata_out(tdata), .fir_tvalid_out(tvalid), .fir_tready_in(tready),
        .fir_res_valid_in(res_valid), .fir_res_data_in(res_data),
        .filtered_out_0(f0), .filtered_out_1(f1), .filtered_out_2(f2),
        .filtered_valid_out(fv), .overrun_out(ovr), .orphan_out(orph)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: what the outputs must be, from the arbitration and routing rules.
    bit          m_pend [3];
    logic [15:0] m_hold [3];
    bit          m_busy;
    logic [15:0] m_data;
    int          m_chan;
    int          m_last = 2;
    int          m_tags [$];
    logic [15:0] m_filt [3];
    bit   [2:0]  m_fv, m_ovr;
    bit          m_orph;

    task automatic model_step();
        int n;
        int g;
        int t;
        logic [15:0] s [3];
        s[0] = s0; s[1] = s1; s[2] = s2;
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_pend[i] = 0; m_hold[i] = '0; m_filt[i] = '0;
            end
            m_busy = 0; m_data = '0; m_chan = 0; m_last = 2;
            m_tags.delete(); m_fv = '0; m_ovr = '0; m_orph = 0;
            return;
        end
        n = m_tags.size();
        g = -1;
        m_fv = '0;
        if (res_valid) begin
            if (n > 0) begin
                t = m_tags.pop_front();
                m_filt[t] = res_data;
                m_fv[t] = 1'b1;
            end else begin
                m_orph = m_orph | STATUS;
            end
        end
        if (!m_busy) begin
            if (n < DEPTH)
                for (int k = 1; k <= 3 && g < 0; k++)
                    if (m_pend[(m_last + k) % 3]) g = (m_last + k) % 3;
            if (g >= 0) begin
                m_busy = 1; m_data = m_hold[g]; m_chan = g; m_last = g; m_pend[g] = 0;
            end
        end else if (tready) begin
            m_tags.push_back(m_chan);
            m_busy = 0;
        end
        for (int i = 0; i < 3; i++) begin
            if (sv[i]) begin
                if (m_pend[i] && g != i) m_ovr[i] = m_ovr[i] | STATUS;
                m_hold[i] = s[i];
                m_pend[i] = 1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        check("cmp_tvalid", tvalid, m_busy);
        check("cmp_tdata", tdata, m_data);
        check("cmp_fvalid", fv, m_fv);
        check("cmp_filt0", f0, m_filt[0]);
        check("cmp_filt1", f1, m_filt[1]);
        check("cmp_filt2", f2, m_filt[2]);
        check("cmp_overrun", ovr, m_ovr);
        check("cmp_orphan", orph, m_orph);
    end

    logic [15:0] issued [$];
    initial forever begin
        @(negedge clk);
        if (!rst && tvalid && tready) begin
            issued.push_back(tdata);
            $display("issue   data=%04h", tdata);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        issued.delete();
    endtask

    task automatic strobe(input logic [2:0] mask, input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        s0 = a; s1 = b; s2 = c; sv = mask;
        $display("strobe  mask=%03b data=%04h %04h %04h", mask, a, b, c);
        tick();
        sv = '0;
    endtask

    task automatic result(input logic [15:0] d);
        res_valid = 1'b1; res_data = d;
        $display("result  data=%04h", d);
        tick();
        res_valid = 1'b0;
    endtask

    task automatic wait_issued(input string name, input int n);
        int c = 0;
        while (issued.size() < n && c < 30) begin
            tick();
            c++;
        end
        check(name, issued.size(), n);
    endtask

    task automatic wait_tvalid(input string name, output int cycles);
        cycles = 0;
        @(negedge clk);
        while (!tvalid && cycles < 20) begin
            cycles++;
            @(negedge clk);
        end
        check(name, tvalid, 1'b1);
    endtask

    initial begin
        int c;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset_tvalid", tvalid, 1'b0);
        check("reset_tdata", tdata, 16'h0000);
        check("reset_fvalid", fv, 3'b000);
        check("reset_overrun", ovr, 3'b000);
        check("reset_orphan", orph, 1'b0);
        tick();

        // Single sample on ch1, FIR always ready.
        tready = 1'b1;
        strobe(3'b010, 16'h0000, 16'h1234, 16'h0000);
        wait_tvalid("t1_tvalid", c);
        check("t1_latency", c, 1);
        check("t1_data", tdata, 16'h1234);
        @(negedge clk);
        check("t1_one_cycle", tvalid, 1'b0);
        tick();
        result(16'h0AAA);
        @(negedge clk);
        check("t1_filt1", f1, 16'h0AAA);
        check("t1_fvalid", fv, 3'b010);
        @(negedge clk);
        check("t1_fvalid_drop", fv, 3'b000);
        tick();

        // Simultaneous strobes issue in channel order after reset.
        do_reset();
        tready = 1'b1;
        strobe(3'b111, 16'h0001, 16'h0002, 16'h0003);
        wait_issued("t2_count", 3);
        check("t2_order0", issued[0], 16'h0001);
        check("t2_order1", issued[1], 16'h0002);
        check("t2_order2", issued[2], 16'h0003);
        result(16'h0010);
        result(16'h0020);
        result(16'h0030);
        @(negedge clk);
        check("t2_filt0", f0, 16'h0010);
        check("t2_filt1", f1, 16'h0020);
        check("t2_filt2", f2, 16'h0030);
        tick();

        // Backpressure: issued data holds; a re-strobe while pending overruns.
        do_reset();
        tready = 1'b0;
        strobe(3'b001, 16'h0004, 16'h0000, 16'h0000);
        wait_tvalid("t3_tvalid", c);
        check("t3_first", tdata, 16'h0004);
        tick();
        strobe(3'b001, 16'h0003, 16'h0000, 16'h0000);
        strobe(3'b001, 16'h0005, 16'h0000, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t3_hold", tdata, 16'h0004);
        end
        check("t3_overrun", ovr, {2'b00, STATUS});
        tick();
        tready = 1'b1;
        wait_issued("t3_count", 2);
        check("t3_issue0", issued[0], 16'h0004);
        check("t3_issue1", issued[1], 16'h0005);
        result(16'h0040);
        result(16'h0050);

        // Tag FIFO full: fifth sample waits until a result frees a slot.
        do_reset();
        tready = 1'b1;
        strobe(3'b111, 16'h0011, 16'h0022, 16'h0033);
        repeat (6) tick();
        strobe(3'b011, 16'h0044, 16'h0055, 16'h0000);
        repeat (20) tick();
        check("t4_blocked_count", issued.size(), 4);
        @(negedge clk);
        check("t4_blocked_tvalid", tvalid, 1'b0);
        tick();
        result(16'h0101);
        @(negedge clk);
        check("t4_first_result", f0, 16'h0101);
        tick();
        wait_issued("t4_count", 5);
        check("t4_fifth", issued[4], 16'h0055);
        result(16'h0202);
        result(16'h0303);
        result(16'h0404);
        result(16'h0505);
        @(negedge clk);
        check("t4_last_result", f1, 16'h0505);
        tick();

        // Orphan result, then reset while a sample is mid-issue.
        do_reset();
        tready = 1'b1;
        result(16'h0BAD);
        @(negedge clk);
        check("t5_no_fvalid", fv, 3'b000);
        check("t5_orphan", orph, STATUS);
        tick();
        tready = 1'b0;
        strobe(3'b100, 16'h0000, 16'h0000, 16'h0777);
        wait_tvalid("t5_tvalid", c);
        check("t5_issue_data", tdata, 16'h0777);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t5_rst_tvalid", tvalid, 1'b0);
        check("t5_rst_tdata", tdata, 16'h0000);
        check("t5_rst_orphan", orph, 1'b0);
        tick();
        tready = 1'b1;
        result(16'h0CCC);
        @(negedge clk);
        check("t5_post_orphan", orph, STATUS);
        check("t5_post_fvalid", fv, 3'b000);
        tick();
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/mic_fir_arbiter.md
MIC_FIR_ARBITER -- requirements
Module: mic_fir_arbiter

Interface
REQ-001 The block SHALL have parameter TAG_DEPTH, default 4, giving the in-flight tag FIFO depth (power of 2, 2..16).
REQ-002 The block SHALL have these ports:
- clk_in, input, 1: the single clock (98.3 MHz audio_clk).
- rst_in, input, 1: synchronous, active-high reset.
- sample_valid_in, input, 3: one-cycle strobe per mic channel (bit i is channel i).
- sample_in_0/1/2, input, 16 each: signed mic sample per channel.
- fir_tdata_out, output, 16: sample issued to the shared FIR.
- fir_tvalid_out, output, 1: FIR input valid.
- fir_tready_in, input, 1: FIR input ready.
- fir_res_valid_in, input, 1: FIR output valid.
- fir_res_data_in, input, 16: FIR output data.
- filtered_out_0/1/2, output, 16 each: last filtered sample per channel.
- filtered_valid_out, output, 3: one-cycle strobe per channel when filtered_out_i updates.
- overrun_out, output, 3: sticky per-channel overrun flag.
- orphan_out, output, 1: sticky flag for a FIR result that arrived with no tag.

Function
REQ-003 Each channel SHALL have a one-entry hold register and pending flag; sample_valid_in[i] at edge N loads sample_in_i and sets pending[i] after edge N.
REQ-004 If sample_valid_in[i] arrives while pending[i]=1 and channel i is not being granted that edge, the hold register SHALL be overwritten and overrun_out[i] set.
REQ-005 If channel i is granted on the same edge that sample_valid_in[i] arrives, the old value SHALL be issued, the new value held, pending[i] remain 1, and no overrun flagged.
REQ-006 The issue FSM SHALL have two states: IDLE (fir_tvalid_out=0) and ISSUE (fir_tvalid_out=1).
REQ-007 In IDLE, with any pending bit set and tag count < TAG_DEPTH, the FSM SHALL grant one channel at the next edge: load fir_tdata_out, clear that pending bit, go to ISSUE.
REQ-008 Grant SHALL be round-robin: search starts at (last_grant+1) mod 3, and last_grant updates on every grant.
REQ-009 In ISSUE, fir_tdata_out SHALL hold stable until an edge with fir_tready_in=1; that edge SHALL push the granted channel ID to the tag FIFO and return to IDLE.
REQ-010 Minimum latency SHALL be: strobe at edge N, fir_tvalid_out high after edge N+1; at most one issue per two cycles.
REQ-011 Issue SHALL be blocked while tag count == TAG_DEPTH, even if a pop occurs that same edge.
REQ-012 fir_res_valid_in=1 with tag FIFO non-empty SHALL pop the head tag t, load filtered_out_t and pulse filtered_valid_out[t] for exactly one cycle after that edge.
REQ-013 fir_res_valid_in=1 with tag FIFO empty SHALL discard the data and set orphan_out.
REQ-014 A push and a pop on the same edge SHALL both take effect, leaving the count unchanged.
REQ-015 Results SHALL be treated as in-order: the FIR preserves sample order and no reordering logic exists.

Reset
REQ-016 While rst_in=1 at an edge, the block SHALL clear:
- all pending bits and hold registers;
- the tag FIFO and its count;
- the FSM to IDLE and last_grant to 2 (so channel 0 wins first);
- fir_tvalid_out, fir_tdata_out, filtered_out_*, filtered_valid_out, overrun_out and orphan_out to 0.
REQ-017 Reset mid-ISSUE SHALL drop fir_tvalid_out the cycle after reset, with no tag pushed; FIR results arriving later SHALL be counted as orphans.

Configuration
REQ-018 With macro MIC_FIR_ARBITER_STATUS_EN defined, overrun_out and orphan_out SHALL behave per REQ-004/REQ-013.
REQ-019 Without MIC_FIR_ARBITER_STATUS_EN, overrun_out and orphan_out SHALL be tied 0 and their registers not synthesized; all other behaviour SHALL be identical.

Verification
REQ-020 Single sample, fir_tready_in=1: strobe ch1 with 0x1234 -> fir_tdata_out=0x1234 with fir_tvalid_out high for 1 cycle; FIR result 0x0AAA -> filtered_out_1=0x0AAA, filtered_valid_out=3'b010 for 1 cycle.
REQ-021 Simultaneous strobes: ch0=0x0001, ch1=0x0002, ch2=0x0003 -> issue order ch0, ch1, ch2; results 0x10, 0x20, 0x30 land on filtered_out_0/1/2 respectively.
REQ-022 Backpressure: fir_tready_in=0 for 10 cycles -> fir_tdata_out held constant; second ch0 strobe of 0x0005 -> overrun_out[0]=1 and 0x0005 issued next.
REQ-023 Tag full, TAG_DEPTH=4: five samples, no results returned -> exactly 4 issued; first result frees a slot and the 5th issues.
REQ-024 Orphan and reset: result with no tags -> orphan_out=1, no filtered_valid_out; rst_in asserted mid-ISSUE -> all outputs 0 next cycle, and a subsequent result sets orphan_out.
REQ-025 Build without MIC_FIR_ARBITER_STATUS_EN -> REQ-022 and REQ-024 stimulus gives overrun_out=0 and orphan_out=0; data results unchanged.
